// File: rtl/load_store_memory.sv
// Handshaked RV32 data memory with built-in load/store unit: byte/half/word
// access with sign/zero extension, fault detection and configurable wait states.
`default_nettype none

module load_store_memory #(
  parameter int DEPTH_LOG2  = 14,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_store,
  input  logic [2:0]  request_funct3,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        response_valid,
  output logic [31:0] response_read_data,
  output logic        response_fault,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACCESS  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  localparam int       DEPTH       = 1 << DEPTH_LOG2;
  localparam int       AW          = DEPTH_LOG2 + 2;
  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam state_t   FIRST_STATE = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic [31:0]       mem [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       mem_word;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data;
  logic              fault;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^request_address[31:AW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    request_ready  = 1'b0;
    response_valid = 1'b0;
    busy           = 1'b1;
    case (state_q)
      S_IDLE: begin
        request_ready = 1'b1;
        busy          = 1'b0;
        if (request_valid) begin
          state_d = FIRST_STATE;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: begin
        response_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && request_valid) begin
        store_q  <= request_store;
        funct3_q <= request_funct3;
        addr_q   <= request_address[AW-1:0];
        wdata_q  <= request_write_data;
      end
      if (state_q == S_ACCESS) begin
        rdata_q <= (store_q || fault) ? 32'd0 : load_data;
        fault_q <= fault;
      end
    end
  end

  always_comb begin
    word_idx  = addr_q[AW-1:2];
    lane      = addr_q[1:0];
    mem_word  = mem[word_idx];
    load_byte = mem_word[{lane, 3'b000} +: 8];
    load_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = 32'd0;
    byte_en   = 4'b0000;
    lane_data = wdata_q;
    fault     = 1'b0;
    case (funct3_q)
      3'b000: begin
        load_data = {{24{load_byte[7]}}, load_byte};
        byte_en   = 4'b0001 << lane;
        lane_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        load_data = {{16{load_half[15]}}, load_half};
        byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
        fault     = addr_q[0];
      end
      3'b010: begin
        load_data = mem_word;
        byte_en   = 4'b1111;
        fault     = (lane != 2'b00);
      end
      3'b100: begin
        load_data = {24'd0, load_byte};
        fault     = store_q;
      end
      3'b101: begin
        load_data = {16'd0, load_half};
        fault     = store_q || addr_q[0];
      end
      default: fault = 1'b1;
    endcase
  end

  // Writes commit only on the ACCESS edge; an async reset earlier forces IDLE.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && store_q && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  assign response_read_data = rdata_q;
  assign response_fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_memory.sv
// Self-checking bench for load_store_memory: three instances (WAIT_STATES 1, 0, 7).
`default_nettype none

module tb_load_store_memory;

  localparam int DEPTH_LOG2 = 14;
  localparam logic [31:0] ALIAS_OFS = 32'(4 * (1 << DEPTH_LOG2));

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_flt;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v    [3];
  logic        st   [3];
  logic [2:0]  f3   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic        flt  [3];
  logic        bsy  [3];

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_memory #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset_n(reset_n),
    .request_valid(v[0]), .request_ready(rdy[0]), .request_store(st[0]),
    .request_funct3(f3[0]), .request_address(addr[0]), .request_write_data(wd[0]),
    .response_valid(rv[0]), .response_read_data(rd[0]), .response_fault(flt[0]),
    .busy(bsy[0]));

  load_store_memory #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n),
    .request_valid(v[1]), .request_ready(rdy[1]), .request_store(st[1]),
    .request_funct3(f3[1]), .request_address(addr[1]), .request_write_data(wd[1]),
    .response_valid(rv[1]), .response_read_data(rd[1]), .response_fault(flt[1]),
    .busy(bsy[1]));

  load_store_memory #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(7)) u_ws7 (
    .clk(clk), .reset_n(reset_n),
    .request_valid(v[2]), .request_ready(rdy[2]), .request_store(st[2]),
    .request_funct3(f3[2]), .request_address(addr[2]), .request_write_data(wd[2]),
    .response_valid(rv[2]), .response_read_data(rd[2]), .response_fault(flt[2]),
    .busy(bsy[2]));

  task automatic drive(input int k, input req_t r);
    v[k]    = 1'b1;
    st[k]   = r.st;
    f3[k]   = r.f3;
    addr[k] = r.a;
    wd[k]   = r.wd;
  endtask

  // Issue one request from IDLE and wait (bounded) for its response.
  task automatic run_req(input int k, input req_t r, output logic [31:0] rd_o,
                         output logic flt_o, output int lat, output bit rdy_low,
                         output logic rdy_back, output bit timeout);
    @(negedge clk);
    drive(k, r);
    @(posedge clk);
    #1 v[k] = 1'b0;
    lat = 0; rdy_low = 1'b1; timeout = 1'b1; rd_o = 'x; flt_o = 1'bx;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (rdy[k] !== 1'b0) rdy_low = 1'b0;
      if (rv[k] === 1'b1) begin
        lat = c; rd_o = rd[k]; flt_o = flt[k]; timeout = 1'b0;
        break;
      end
    end
    @(negedge clk);
    rdy_back = rdy[k];
  endtask

  task automatic test_reset();
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL reset.ready got %b want 1", rdy[0]); end
    tests++; if (rv[0] !== 1'b0) begin fails++; $display("FAIL reset.valid got %b want 0", rv[0]); end
    tests++; if (rd[0] !== 32'd0) begin fails++; $display("FAIL reset.rdata got %h want 0", rd[0]); end
    tests++; if (flt[0] !== 1'b0) begin fails++; $display("FAIL reset.fault got %b want 0", flt[0]); end
    tests++; if (bsy[0] !== 1'b0) begin fails++; $display("FAIL reset.busy got %b want 0", bsy[0]); end
  endtask

  task automatic test_word_latency();
    req_t tbl[2];
    exp_t e;
    logic [31:0] r; logic f, rb; int lat; bit rl, to;
    tbl[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0};
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].exp_rd, tbl[i].exp_flt});
      run_req(0, tbl[i], r, f, lat, rl, rb, to);
      e = sb.pop_front();
      tests++;
      if (to) begin fails++; $display("FAIL word[%0d] timeout, no response", i); end
      else begin
        tests++; if (lat != 3) begin fails++; $display("FAIL word[%0d].latency got %0d want 3", i, lat); end
        tests++; if (!rl) begin fails++; $display("FAIL word[%0d].ready_low got high want low", i); end
        tests++; if (rb !== 1'b1) begin fails++; $display("FAIL word[%0d].ready_back got %b want 1", i, rb); end
        tests++; if (r !== e.rd) begin fails++; $display("FAIL word[%0d].rdata got %h want %h", i, r, e.rd); end
        tests++; if (f !== e.flt) begin fails++; $display("FAIL word[%0d].fault got %b want %b", i, f, e.flt); end
      end
    end
  endtask

  task automatic test_subword();
    req_t tbl[8];
    exp_t e;
    logic [31:0] r; logic f, rb; int lat; bit rl, to;
    tbl[0] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0};
    tbl[1] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 1'b0};
    tbl[2] = '{1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0};
    tbl[3] = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h0000BEEF, 1'b0};
    tbl[4] = '{1'b1, 3'b000, 32'h101, 32'h12345677, 32'h0, 1'b0};
    tbl[5] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD77EF, 1'b0};
    tbl[6] = '{1'b1, 3'b001, 32'h102, 32'hAAAA5555, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h555577EF, 1'b0};
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].exp_rd, tbl[i].exp_flt});
      run_req(0, tbl[i], r, f, lat, rl, rb, to);
      e = sb.pop_front();
      tests++;
      if (to) begin fails++; $display("FAIL subword[%0d] timeout, no response", i); end
      else begin
        tests++; if (r !== e.rd) begin fails++; $display("FAIL subword[%0d].rdata got %h want %h", i, r, e.rd); end
        tests++; if (f !== e.flt) begin fails++; $display("FAIL subword[%0d].fault got %b want %b", i, f, e.flt); end
      end
    end
  endtask

  task automatic test_faults();
    req_t tbl[5];
    exp_t e;
    logic [31:0] r; logic f, rb; int lat; bit rl, to;
    tbl[0] = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1};
    tbl[1] = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1};
    tbl[2] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h555577EF, 1'b0};
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].exp_rd, tbl[i].exp_flt});
      run_req(0, tbl[i], r, f, lat, rl, rb, to);
      e = sb.pop_front();
      tests++;
      if (to) begin fails++; $display("FAIL fault[%0d] timeout, no response", i); end
      else begin
        tests++; if (r !== e.rd) begin fails++; $display("FAIL fault[%0d].rdata got %h want %h", i, r, e.rd); end
        tests++; if (f !== e.flt) begin fails++; $display("FAIL fault[%0d].fault got %b want %b", i, f, e.flt); end
      end
    end
  endtask

  // request_valid held high; next payload is presented right after each accept.
  task automatic test_back_to_back(input int k, input int ws, input logic [31:0] pat);
    req_t tbl[3];
    exp_t e;
    int idx, got, last;
    bit adv;
    tbl[0] = '{1'b1, 3'b010, 32'h100, pat, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 3'b010, 32'h100 + ALIAS_OFS, 32'h0, pat, 1'b0};
    tbl[2] = '{1'b0, 3'b010, 32'h100, 32'h0, pat, 1'b0};
    idx = 0; got = 0; last = -1; adv = 1'b0;
    @(negedge clk);
    drive(k, tbl[0]);
    for (int c = 0; c < 300 && got < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (rv[k] === 1'b1) begin
        got++;
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL b2b_ws%0d unexpected response rdata %h", ws, rd[k]);
        end else begin
          e = sb.pop_front();
          tests++; if (rd[k] !== e.rd) begin fails++; $display("FAIL b2b_ws%0d[%0d].rdata got %h want %h", ws, got - 1, rd[k], e.rd); end
          tests++; if (flt[k] !== e.flt) begin fails++; $display("FAIL b2b_ws%0d[%0d].fault got %b want %b", ws, got - 1, flt[k], e.flt); end
        end
      end
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) drive(k, tbl[idx]);
        else         v[k] = 1'b0;
      end
      if (v[k] && rdy[k] === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (c - last != ws + 3) begin fails++; $display("FAIL b2b_ws%0d.spacing got %0d want %0d", ws, c - last, ws + 3); end
        end
        last = c;
        sb.push_back('{tbl[idx].exp_rd, tbl[idx].exp_flt});
        adv = 1'b1;
      end
    end
    v[k] = 1'b0;
    tests++;
    if (got < 3) begin fails++; $display("FAIL b2b_ws%0d timeout, responses got %0d want 3", ws, got); end
    sb.delete();
  endtask

  task automatic test_reset_mid_op();
    req_t r0, r1, r2;
    logic [31:0] r; logic f, rb; int lat; bit rl, to, seen;
    r0 = '{1'b1, 3'b010, 32'h200, 32'h0BADF00D, 32'h0, 1'b0};
    r1 = '{1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 1'b0};
    r2 = '{1'b1, 3'b010, 32'h200, 32'h11111111, 32'h0, 1'b0};
    run_req(0, r0, r, f, lat, rl, rb, to);
    run_req(0, r1, r, f, lat, rl, rb, to);
    tests++; if (to || r !== 32'h0BADF00D) begin fails++; $display("FAIL midrst.preload got %h want 0badf00d", r); end
    @(negedge clk);
    drive(0, r2);
    @(posedge clk);
    #1 v[0] = 1'b0;
    @(negedge clk);
    tests++; if (bsy[0] !== 1'b1) begin fails++; $display("FAIL midrst.busy_wait got %b want 1", bsy[0]); end
    tests++; if (rd[0] !== 32'h0BADF00D) begin fails++; $display("FAIL midrst.hold got %h want 0badf00d", rd[0]); end
    #1 reset_n = 1'b0;
    #1;
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL midrst.ready got %b want 1", rdy[0]); end
    tests++; if (bsy[0] !== 1'b0) begin fails++; $display("FAIL midrst.busy got %b want 0", bsy[0]); end
    tests++; if (rd[0] !== 32'd0) begin fails++; $display("FAIL midrst.rdata got %h want 0", rd[0]); end
    tests++; if (flt[0] !== 1'b0) begin fails++; $display("FAIL midrst.fault got %b want 0", flt[0]); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rv[0] !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst.no_response got pulse want none"); end
    sb.push_back('{32'h0BADF00D, 1'b0});
    run_req(0, r1, r, f, lat, rl, rb, to);
    tests++;
    if (to) begin fails++; $display("FAIL midrst.reload timeout, no response"); sb.delete(); end
    else begin
      exp_t e;
      e = sb.pop_front();
      tests++; if (r !== e.rd) begin fails++; $display("FAIL midrst.reload got %h want %h", r, e.rd); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; st[k] = 1'b0; f3[k] = 3'd0; addr[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_word_latency();
    test_subword();
    test_faults();
    test_back_to_back(1, 0, 32'hCAFEF00D);
    test_back_to_back(2, 7, 32'h7E57DA7A);
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
